vga_sprite_engine: RTL and testbench

- Parametrised successor of the fixed 640x480 VGA top-level.
- Generates programmable VGA timing and fetches one SPR_W x SPR_H RGB565 sprite from an external synchronous ROM.
- Composites the sprite over a background colour with colour-key transparency.
- Sprite position is loaded through a valid/ready handshake and takes effect only at a frame boundary, so no frame shows a torn sprite.
- Sits between the PLL pixel clock and the VGA DAC pins.

---
 rtl/vga_sprite_engine_if.sv | 11 +
 rtl/vga_sprite_engine.sv | 182 ++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sprite_engine_if.sv
// Sprite position request channel: the master offers a top-left position,
// and the engine accepts it when its single pending slot is free.
interface vga_sprite_engine_if;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic        pos_valid;
    logic        pos_ready;

    modport master (output pos_x, output pos_y, output pos_valid, input pos_ready);
    modport slave  (input pos_x, input pos_y, input pos_valid, output pos_ready);
endinterface

// File: rtl/vga_sprite_engine.sv
// Programmable VGA timing with one ROM-backed RGB565 sprite, colour-key transparency
// and frame-synchronous position updates. Define VGA_SPRITE_BOUNCE_EN for autonomous bouncing.
module vga_sprite_engine #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int          SPR_W      = 64,
    parameter int          SPR_H      = 64,
    parameter int          ROM_AW     = 12,
    parameter int          ROM_LAT    = 1,
    parameter logic [15:0] TRANSP_KEY = 16'hF81F,
    parameter logic [15:0] BG_COLOR   = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    vga_sprite_engine_if.slave pos,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [15:0]        rom_data,
    output logic               HSYNC_Sig,
    output logic               VSYNC_Sig,
    output logic               de,
    output logic               frame_start,
    output logic [4:0]         Red_Sig,
    output logic [5:0]         Green_Sig,
    output logic [4:0]         Blue_Sig
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW      = 13;
    localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - SPR_W);
    localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - SPR_H);

    typedef struct packed {
        logic hit;
        logic act;
        logic hs;
        logic vs;
        logic fs;
    } tap_t;

    logic [CW-1:0]     h_cnt_reg, v_cnt_reg;
    logic [CW-1:0]     cur_x_reg, cur_y_reg, pend_x_reg, pend_y_reg;
    logic              pending_reg;
    logic [ROM_AW-1:0] rom_addr_reg;
    tap_t              dly_reg [0:ROM_LAT];
    logic              hsync_reg, vsync_reg, de_reg, fs_reg;
    logic [15:0]       rgb_reg;

    logic          hs_raw, vs_raw, act_raw, hit_raw, fs_raw, apply_pt, xfer;
    logic [CW-1:0] row_off, col_off, req_x, req_y;
    logic [23:0]   addr_full;
    tap_t          tap_raw, tap_out;

    assign hs_raw  = (h_cnt_reg >= CW'(H_ACTIVE + H_FP)) && (h_cnt_reg < CW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw  = (v_cnt_reg >= CW'(V_ACTIVE + V_FP)) && (v_cnt_reg < CW'(V_ACTIVE + V_FP + V_SYNC));
    assign act_raw = (h_cnt_reg < CW'(H_ACTIVE)) && (v_cnt_reg < CW'(V_ACTIVE));
    assign fs_raw  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    assign hit_raw = act_raw
                   && (h_cnt_reg >= cur_x_reg) && (h_cnt_reg < cur_x_reg + CW'(SPR_W))
                   && (v_cnt_reg >= cur_y_reg) && (v_cnt_reg < cur_y_reg + CW'(SPR_H));
    assign row_off   = v_cnt_reg - cur_y_reg;
    assign col_off   = h_cnt_reg - cur_x_reg;
    assign addr_full = 24'(row_off) * 24'(SPR_W) + 24'(col_off);
    assign tap_raw   = '{hit: hit_raw, act: act_raw, hs: hs_raw, vs: vs_raw, fs: fs_raw};
    assign tap_out   = dly_reg[ROM_LAT];

    // Position updates land at the start of vertical blank so a frame never shows a torn sprite.
    assign apply_pt      = (h_cnt_reg == '0) && (v_cnt_reg == CW'(V_ACTIVE));
    assign pos.pos_ready = !pending_reg && !rst;
    assign xfer          = pos.pos_valid && !pending_reg;
    assign req_x = ({1'b0, pos.pos_x} > X_MAX) ? X_MAX : {1'b0, pos.pos_x};
    assign req_y = ({1'b0, pos.pos_y} > Y_MAX) ? Y_MAX : {1'b0, pos.pos_y};

`ifdef VGA_SPRITE_BOUNCE_EN
    logic dx_neg_reg, dy_neg_reg;
    logic dx_flip, dy_flip;
    assign dx_flip = dx_neg_reg ? (cur_x_reg == '0) : (cur_x_reg >= X_MAX);
    assign dy_flip = dy_neg_reg ? (cur_y_reg == '0) : (cur_y_reg >= Y_MAX);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
            cur_x_reg   <= '0;
            cur_y_reg   <= '0;
            pend_x_reg  <= '0;
            pend_y_reg  <= '0;
            pending_reg <= 1'b0;
`ifdef VGA_SPRITE_BOUNCE_EN
            dx_neg_reg  <= 1'b0;
            dy_neg_reg  <= 1'b0;
`endif
        end else begin
            if (h_cnt_reg == CW'(H_TOTAL - 1)) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= (v_cnt_reg == CW'(V_TOTAL - 1)) ? '0 : v_cnt_reg + CW'(1);
            end else begin
                h_cnt_reg <= h_cnt_reg + CW'(1);
            end

            if (xfer) begin
                pending_reg <= 1'b1;
                pend_x_reg  <= req_x;
                pend_y_reg  <= req_y;
            end

            if (apply_pt) begin
                if (pending_reg) begin
                    cur_x_reg   <= pend_x_reg;
                    cur_y_reg   <= pend_y_reg;
                    pending_reg <= 1'b0;
                end
`ifdef VGA_SPRITE_BOUNCE_EN
                else begin
                    // After a flip the sprite already steps in the new direction.
                    dx_neg_reg <= dx_neg_reg ^ dx_flip;
                    dy_neg_reg <= dy_neg_reg ^ dy_flip;
                    cur_x_reg  <= (dx_neg_reg ^ dx_flip) ? cur_x_reg - CW'(1) : cur_x_reg + CW'(1);
                    cur_y_reg  <= (dy_neg_reg ^ dy_flip) ? cur_y_reg - CW'(1) : cur_y_reg + CW'(1);
                end
`endif
            end
        end
    end

    // Stage 1 issues the ROM read; the delay line keeps the flags in step with rom_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_reg <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                dly_reg[i] <= '0;
            end
        end else begin
            if (hit_raw) begin
                rom_addr_reg <= addr_full[ROM_AW-1:0];
            end
            dly_reg[0] <= tap_raw;
            for (int i = 1; i <= ROM_LAT; i++) begin
                dly_reg[i] <= dly_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_reg <= ~HS_POL;
            vsync_reg <= ~VS_POL;
            de_reg    <= 1'b0;
            fs_reg    <= 1'b0;
            rgb_reg   <= '0;
        end else begin
            hsync_reg <= tap_out.hs ? HS_POL : ~HS_POL;
            vsync_reg <= tap_out.vs ? VS_POL : ~VS_POL;
            de_reg    <= tap_out.act;
            fs_reg    <= tap_out.fs;
            if (tap_out.hit && (rom_data != TRANSP_KEY)) begin
                rgb_reg <= rom_data;
            end else if (tap_out.act) begin
                rgb_reg <= BG_COLOR;
            end else begin
                rgb_reg <= '0;
            end
        end
    end

    assign rom_addr    = rom_addr_reg;
    assign HSYNC_Sig   = hsync_reg;
    assign VSYNC_Sig   = vsync_reg;
    assign de          = de_reg;
    assign frame_start = fs_reg;
    assign Red_Sig     = rgb_reg[15:11];
    assign Green_Sig   = rgb_reg[10:5];
    assign Blue_Sig    = rgb_reg[4:0];
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine: two instances (ROM latency 1 and 2) on a reduced raster,
// scored every clock against a frame-level model of timing, sprite placement and handshake.
module tb_vga_sprite_engine;
    localparam int HA = 40, HFP = 4, HSW = 6, HBP = 6;
    localparam int VA = 30, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int SW = 8, SH = 8, AW = 6;
    localparam int XMAX = HA - SW, YMAX = VA - SH;
    localparam logic [15:0] KEY = 16'hF81F;
    localparam logic [15:0] BG  = 16'h001F;
    localparam logic [19:0] RST_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sprite_engine_if if1();
    vga_sprite_engine_if if2();

    logic [AW-1:0] addr1, addr2;
    logic [15:0]   data1, data2;
    logic          hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;
    logic [4:0]    r1, b1, r2, b2;
    logic [5:0]    g1, g2;

    vga_sprite_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .SPR_W(SW), .SPR_H(SH), .ROM_AW(AW),
        .ROM_LAT(1), .TRANSP_KEY(KEY), .BG_COLOR(BG)
    ) dut1 (
        .clk(clk), .rst(rst), .pos(if1), .rom_addr(addr1), .rom_data(data1),
        .HSYNC_Sig(hs1), .VSYNC_Sig(vs1), .de(de1), .frame_start(fs1),
        .Red_Sig(r1), .Green_Sig(g1), .Blue_Sig(b1)
    );

    vga_sprite_engine #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .SPR_W(SW), .SPR_H(SH), .ROM_AW(AW),
        .ROM_LAT(2), .TRANSP_KEY(KEY), .BG_COLOR(BG)
    ) dut2 (
        .clk(clk), .rst(rst), .pos(if2), .rom_addr(addr2), .rom_data(data2),
        .HSYNC_Sig(hs2), .VSYNC_Sig(vs2), .de(de2), .frame_start(fs2),
        .Red_Sig(r2), .Green_Sig(g2), .Blue_Sig(b2)
    );

    // Sprite ROMs with one- and two-clock read latency sharing one image.
    logic [15:0] rom_mem [0:63];
    logic [15:0] rom1_q, rom2_a, rom2_q;
    always @(posedge clk) begin
        rom1_q <= rom_mem[addr1];
        rom2_a <= rom_mem[addr2];
        rom2_q <= rom2_a;
    end
    assign data1 = rom1_q;
    assign data2 = rom2_q;

    int checks = 0;
    int errors = 0;

    // Model: raster position during the current clock, sprite position in effect, pending slot.
    int m_h = 0, m_v = 0, m_cx = 0, m_cy = 0, m_px = 0, m_py = 0;
    bit m_pend = 1'b0;
    bit m_in_reset = 1'b1;
    int m_dx = 1, m_dy = 1;

    always @(posedge clk) begin
        bit take;
        if (rst) begin
            m_h = 0; m_v = 0; m_cx = 0; m_cy = 0;
            m_pend = 1'b0; m_in_reset = 1'b1; m_dx = 1; m_dy = 1;
        end else begin
            m_in_reset = 1'b0;
            take = if1.pos_valid && !m_pend;
            if (m_h == 0 && m_v == VA) begin
                if (m_pend) begin
                    m_cx = m_px; m_cy = m_py; m_pend = 1'b0;
                end
`ifdef VGA_SPRITE_BOUNCE_EN
                else begin
                    if (m_cx + m_dx < 0 || m_cx + m_dx > XMAX) m_dx = -m_dx;
                    if (m_cy + m_dy < 0 || m_cy + m_dy > YMAX) m_dy = -m_dy;
                    m_cx = m_cx + m_dx;
                    m_cy = m_cy + m_dy;
                end
`endif
            end
            if (take) begin
                m_pend = 1'b1;
                m_px = (int'(if1.pos_x) > XMAX) ? XMAX : int'(if1.pos_x);
                m_py = (int'(if1.pos_y) > YMAX) ? YMAX : int'(if1.pos_y);
            end
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end
        end
    end

    // What the pins should show for raster position (h, v) with the sprite at (cx, cy).
    function automatic logic [19:0] model_out(int h, int v, int cx, int cy);
        logic hs, vs, act, hit, fs;
        logic [15:0] px, rgb;
        hs  = !(h >= HA + HFP && h < HA + HFP + HSW);
        vs  = !(v >= VA + VFP && v < VA + VFP + VSW);
        act = (h < HA) && (v < VA);
        hit = act && h >= cx && h < cx + SW && v >= cy && v < cy + SH;
        fs  = (h == 0) && (v == 0);
        px  = hit ? rom_mem[(v - cy) * SW + (h - cx)] : 16'h0000;
        rgb = !act ? 16'h0000 : ((hit && px != KEY) ? px : BG);
        return {hs, vs, act, fs, rgb};
    endfunction

    logic [19:0] q1[$];
    logic [19:0] q2[$];

    always @(negedge clk) begin
        logic [19:0] cur, exp1, exp2, got1, got2;
        got1 = {hs1, vs1, de1, fs1, r1, g1, b1};
        got2 = {hs2, vs2, de2, fs2, r2, g2, b2};
        cur  = model_out(m_h, m_v, m_cx, m_cy);
        if (m_in_reset) begin
            q1.delete();
            q2.delete();
        end
        q1.push_back(cur);
        q2.push_back(cur);
        exp1 = (q1.size() > 3) ? q1.pop_front() : RST_OUT;
        exp2 = (q2.size() > 4) ? q2.pop_front() : RST_OUT;
        checks += 2;
        if (got1 !== exp1) begin
            errors++;
            $display("FAIL pixel_lat1 t=%0t hs,vs,de,fs,rgb got %h expected %h", $time, got1, exp1);
        end
        if (got2 !== exp2) begin
            errors++;
            $display("FAIL pixel_lat2 t=%0t hs,vs,de,fs,rgb got %h expected %h", $time, got2, exp2);
        end
    end

    task automatic drive_pos(input int x, input int y, input bit v);
        if1.pos_x = 12'(x); if1.pos_y = 12'(y); if1.pos_valid = v;
        if2.pos_x = 12'(x); if2.pos_y = 12'(y); if2.pos_valid = v;
    endtask

    task automatic wait_pos(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2 * HT * VT; n++) begin
            if (m_h == h && m_v == v) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int first1, first2;
        rst = 1'b1;
        drive_pos(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (if1.pos_ready !== 1'b0 || if2.pos_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b/%b expected 0/0", if1.pos_ready, if2.pos_ready);
        end
        checks++;
        if ({hs1, vs1, de1, fs1, addr1, addr2} !== {4'b1100, 12'h000}) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b%b addr %h/%h expected 1100 addr 00/00", hs1, vs1, de1, fs1, addr1, addr2);
        end
        rst = 1'b0;
        first1 = -1;
        first2 = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (fs1 === 1'b1 && first1 < 0) first1 = k;
            if (fs2 === 1'b1 && first2 < 0) first2 = k;
            if (k == 1) begin
                checks++;
                if (if1.pos_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_reset got %b expected 1", if1.pos_ready);
                end
            end
        end
        checks++;
        if (first1 != 3) begin
            errors++;
            $display("FAIL first_frame_start_lat1 got clock %0d expected 3", first1);
        end
        checks++;
        if (first2 != 4) begin
            errors++;
            $display("FAIL first_frame_start_lat2 got clock %0d expected 4", first2);
        end
    endtask

    task automatic test_sync_timing;
        int line_low, hs_low, vs_low, de_cnt, shift_bad;
        logic [19:0] prev1;
        line_low = 0; hs_low = 0; vs_low = 0; de_cnt = 0; shift_bad = 0;
        prev1 = {hs1, vs1, de1, fs1, r1, g1, b1};
        for (int k = 0; k < HT * VT; k++) begin
            @(negedge clk);
            if (hs1 === 1'b0) begin
                hs_low++;
                if (k < HT) line_low++;
            end
            if (vs1 === 1'b0) vs_low++;
            if (de1 === 1'b1) de_cnt++;
            if ({hs2, vs2, de2, fs2, r2, g2, b2} !== prev1) shift_bad++;
            prev1 = {hs1, vs1, de1, fs1, r1, g1, b1};
        end
        checks++;
        if (line_low != HSW) begin
            errors++;
            $display("FAIL hsync_line_width got %0d expected %0d", line_low, HSW);
        end
        checks++;
        if (hs_low != HSW * VT) begin
            errors++;
            $display("FAIL hsync_frame_low got %0d expected %0d", hs_low, HSW * VT);
        end
        checks++;
        if (vs_low != VSW * HT) begin
            errors++;
            $display("FAIL vsync_frame_low got %0d expected %0d", vs_low, VSW * HT);
        end
        checks++;
        if (de_cnt != HA * VA) begin
            errors++;
            $display("FAIL de_count got %0d expected %0d", de_cnt, HA * VA);
        end
        checks++;
        if (shift_bad != 0) begin
            errors++;
            $display("FAIL lat2_one_clock_shift got %0d misaligned clocks expected 0", shift_bad);
        end
    endtask

    task automatic test_load_pos(input int x, input int y);
        bit ok;
        int ex, ey, early;
        ex = (x > XMAX) ? XMAX : x;
        ey = (y > YMAX) ? YMAX : y;
        wait_pos(0, VA / 2, ok);
        checks++;
        if (!ok || if1.pos_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_before (%0d,%0d) got ok=%b ready=%b expected 1/1", x, y, ok, if1.pos_ready);
        end
        drive_pos(x, y, 1'b1);
        @(negedge clk);
        drive_pos(0, 0, 1'b0);
        early = 0;
        for (int n = 0; n < HT * VT; n++) begin
            if (if1.pos_ready !== 1'b0 || if2.pos_ready !== 1'b0) early++;
            if (m_h == 0 && m_v == VA) break;
            @(negedge clk);
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL load_ready_held_low (%0d,%0d) got %0d high clocks expected 0", x, y, early);
        end
        @(negedge clk);
        checks++;
        if (if1.pos_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_after_apply got %b expected 1", if1.pos_ready);
        end
        wait_pos(ex, ey, ok);
        @(negedge clk);
        checks++;
        if (!ok || addr1 !== AW'(0) || addr2 !== AW'(0)) begin
            errors++;
            $display("FAIL load_first_addr at (%0d,%0d) got %0d/%0d expected 0", ex, ey, addr1, addr2);
        end
        wait_pos(ex + SW - 1, ey + SH - 1, ok);
        @(negedge clk);
        checks++;
        if (!ok || addr1 !== AW'(SW * SH - 1) || addr2 !== AW'(SW * SH - 1)) begin
            errors++;
            $display("FAIL load_last_addr at (%0d,%0d) got %0d/%0d expected %0d", ex + SW - 1, ey + SH - 1, addr1, addr2, SW * SH - 1);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        wait_pos(0, VA, ok);
        @(negedge clk);
        drive_pos(20, 12, 1'b1);
        @(negedge clk);
        drive_pos(0, 0, 1'b0);
        wait_pos(20, 15, ok);
        checks++;
        if (!ok || if1.pos_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pending got ok=%b ready=%b expected 1/0", ok, if1.pos_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({hs1, vs1, de1, fs1, r1, g1, b1, addr1} !== {4'b1100, 16'h0000, 6'h00}) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b%b%b%b rgb %h addr %h expected 1100 0000 00", hs1, vs1, de1, fs1, {r1, g1, b1}, addr1);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if1.pos_ready !== 1'b1 || if2.pos_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_drop_pending got ready %b/%b expected 1/1", if1.pos_ready, if2.pos_ready);
        end
    endtask

    task automatic test_transparency;
        bit ok;
        wait_pos(4, 0, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || {r1, g1, b1} !== rom_mem[4]) begin
            errors++;
            $display("FAIL transp_left_neighbour got %h expected %h", {r1, g1, b1}, rom_mem[4]);
        end
        @(negedge clk);
        checks++;
        if ({r1, g1, b1} !== BG) begin
            errors++;
            $display("FAIL transp_key_pixel got %h expected %h", {r1, g1, b1}, BG);
        end
        @(negedge clk);
        checks++;
        if ({r1, g1, b1} !== rom_mem[6]) begin
            errors++;
            $display("FAIL transp_right_neighbour got %h expected %h", {r1, g1, b1}, rom_mem[6]);
        end
    endtask

`ifdef VGA_SPRITE_BOUNCE_EN
    task automatic test_bounce;
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 10; f++) begin
            wait_pos(0, VA, ok);
            @(negedge clk);
        end
        wait_pos(10, 10, ok);
        @(negedge clk);
        checks++;
        if (!ok || addr1 !== AW'(0)) begin
            errors++;
            $display("FAIL bounce_ten_frames got addr %0d at (10,10) expected 0", addr1);
        end
    endtask
`endif

    task automatic test_random;
        int gap, hold, bad;
        bad = 0;
        for (int it = 0; it < 6; it++) begin
            gap = $urandom_range(0, HT * VT);
            for (int n = 0; n < gap; n++) begin
                @(negedge clk);
                if (if1.pos_ready !== !m_pend || if2.pos_ready !== !m_pend) bad++;
            end
            drive_pos($urandom_range(0, 60), $urandom_range(0, 45), 1'b1);
            hold = $urandom_range(1, 3);
            for (int n = 0; n < hold; n++) begin
                @(negedge clk);
                if (if1.pos_ready !== !m_pend || if2.pos_ready !== !m_pend) bad++;
            end
            drive_pos(0, 0, 1'b0);
        end
        repeat (HT * VT) @(negedge clk);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_pos_ready got %0d wrong clocks expected 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom_mem[i] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rom_mem[i] = KEY;
        end
        rom_mem[4] = 16'h07E0;
        rom_mem[5] = KEY;
        rom_mem[6] = 16'hABCD;
        drive_pos(0, 0, 1'b0);

        test_reset();
        test_sync_timing();
        test_load_pos(12, 9);
        test_load_pos(700, 470);
        test_reset_mid();
        test_transparency();
`ifdef VGA_SPRITE_BOUNCE_EN
        test_bounce();
`endif
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
